// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, MEM-stage FSM states and access sizes.
// Also provides the alignment rule used to decide whether an access may go out.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_aligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return ~off[0];
      SZ_W:    return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection for a big-endian bus: offset 0 is bits 31:24.
// Extracts the byte or halfword and sign- or zero-extends it to 32 bits.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    data   = rdata;

    case (off)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[15:0] : rdata[31:16];

    if (size == SZ_B) begin
      data = uns ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
    end else if (size == SZ_H) begin
      data = uns ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
    end
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage: issues loads/stores on a req/ack bus, passes ALU results
// through with one cycle of latency and stalls upstream while an access is open.
module mem_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic [31:0] Wdata,
  output logic [4:0]  WbReg,
  output logic        WbEn,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;

  logic [5:0]  opcode;
  logic        is_load, is_store, is_mem, aligned, uns, alu_wr;
  size_t       size;
  logic [4:0]  dest;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;

  logic        start, misalign, pass, ack_done, tmo;

  logic [1:0]  ld_off;
  logic [1:0]  ld_size;
  logic        ld_uns, ld_is_load;
  logic [4:0]  ld_rt;
  logic [31:0] load_val;

  logic        unused_bits;
  assign unused_bits = ^{Ins[25:21], Ins[10:0]};

  // Instruction decode and store lane/byte-enable generation.
  always_comb begin
    opcode   = Ins[31:26];
    is_load  = 1'b0;
    is_store = 1'b0;
    uns      = 1'b0;
    size     = SZ_W;
    case (opcode)
      OP_LB:   begin is_load  = 1'b1; size = SZ_B; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_H; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_B; uns = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_H; uns = 1'b1; end
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      OP_SW:   begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
    is_mem  = is_load | is_store;
    aligned = is_aligned(size, Result[1:0]);
    dest    = (opcode == OP_RTYPE) ? Ins[15:11] : Ins[20:16];
    alu_wr  = (opcode == OP_RTYPE) || (opcode[5:3] == 3'b001);

    case (size)
      SZ_B: begin
        be_calc = 4'b1000 >> Result[1:0];
        wd_calc = {4{Rdata2[7:0]}};
      end
      SZ_H: begin
        be_calc = Result[1] ? 4'b0011 : 4'b1100;
        wd_calc = {2{Rdata2[15:0]}};
      end
      default: begin
        be_calc = 4'b1111;
        wd_calc = Rdata2;
      end
    endcase
  end

  // Next state and stall; in BUSY the timeout cycle releases the stall
  // because the instruction is abandoned on the following edge.
  always_comb begin
    state_next = state;
    Stall      = 1'b0;
    start      = 1'b0;
    misalign   = 1'b0;
    pass       = 1'b0;
    ack_done   = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if (Valid) begin
          if (is_mem && aligned) begin
            Stall      = 1'b1;
            start      = 1'b1;
            state_next = BUSY;
          end else if (is_mem) begin
            misalign = 1'b1;
          end else begin
            pass = 1'b1;
          end
        end
      end
      BUSY: begin
        if (MemAck) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          tmo        = 1'b1;
          state_next = IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  load_align u_load_align (
    .rdata (MemRdata),
    .off   (ld_off),
    .size  (ld_size),
    .uns   (ld_uns),
    .data  (load_val)
  );

  // Bus registers, held access context, timeout counter and write-back outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MemReq     <= 1'b0;
      MemWe      <= 1'b0;
      MemAddr    <= 32'h0;
      MemBe      <= 4'h0;
      MemWdata   <= 32'h0;
      Wdata      <= 32'h0;
      WbReg      <= 5'd0;
      WbEn       <= 1'b0;
      AddrErr    <= 1'b0;
      BusErr     <= 1'b0;
      cnt        <= 8'd0;
      ld_off     <= 2'b00;
      ld_size    <= 2'b00;
      ld_uns     <= 1'b0;
      ld_is_load <= 1'b0;
      ld_rt      <= 5'd0;
    end else begin
      WbEn    <= 1'b0;
      AddrErr <= 1'b0;
      BusErr  <= 1'b0;

      if (start) begin
        MemReq     <= 1'b1;
        MemWe      <= is_store;
        MemAddr    <= {Result[31:2], 2'b00};
        MemBe      <= be_calc;
        MemWdata   <= wd_calc;
        cnt        <= 8'd0;
        ld_off     <= Result[1:0];
        ld_size    <= size;
        ld_uns     <= uns;
        ld_is_load <= is_load;
        ld_rt      <= Ins[20:16];
      end else if (ack_done || tmo) begin
        MemReq <= 1'b0;
        cnt    <= 8'd0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end

      if (ack_done && ld_is_load) begin
        Wdata <= load_val;
        WbReg <= ld_rt;
        WbEn  <= (ld_rt != 5'd0);
      end

      if (tmo)      BusErr  <= 1'b1;
      if (misalign) AddrErr <= 1'b1;

      if (pass) begin
        Wdata <= Result;
        WbReg <= dest;
        WbEn  <= alu_wr && (dest != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for the MEM stage: ALU pass-through, loads,
// stores, misalignment, bus timeout and asynchronous reset mid-access.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Valid;
  logic [31:0] Ins, Result, Rdata2;
  logic        Stall, MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata, MemRdata;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] Wdata;
  logic [4:0]  WbReg;
  logic        WbEn, AddrErr, BusErr;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  mem_access #(.TIMEOUT(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Valid    (Valid),
    .Ins      (Ins),
    .Result   (Result),
    .Rdata2   (Rdata2),
    .Stall    (Stall),
    .MemReq   (MemReq),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemBe    (MemBe),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata),
    .MemAck   (MemAck),
    .Wdata    (Wdata),
    .WbReg    (WbReg),
    .WbEn     (WbEn),
    .AddrErr  (AddrErr),
    .BusErr   (BusErr)
  );

  task test_reset();
    RST = 1'b1; Valid = 1'b0; Ins = 32'h0; Result = 32'h0; Rdata2 = 32'h0;
    MemRdata = 32'h0; MemAck = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    total++; if ({MemReq, MemWe, WbEn, AddrErr, BusErr, Stall} !== 6'b0) $display("[TB] FAIL reset_ctrl got %b exp 000000", {MemReq, MemWe, WbEn, AddrErr, BusErr, Stall}); else passed++;
    total++; if ({MemAddr, MemBe, MemWdata} !== 68'h0) $display("[TB] FAIL reset_bus got %h exp 0", {MemAddr, MemBe, MemWdata}); else passed++;
    total++; if ({Wdata, WbReg} !== 37'h0) $display("[TB] FAIL reset_wb got %h exp 0", {Wdata, WbReg}); else passed++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task test_alu();
    Valid = 1'b1; Ins = 32'h00851020; Result = 32'h8;
    #1;
    total++; if (Stall !== 1'b0) $display("[TB] FAIL alu_stall got %b exp 0", Stall); else passed++;
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    total++; if (Wdata !== 32'h8) $display("[TB] FAIL alu_wdata got %h exp 00000008", Wdata); else passed++;
    total++; if (WbReg !== 5'd2) $display("[TB] FAIL alu_wbreg got %0d exp 2", WbReg); else passed++;
    total++; if ({WbEn, MemReq} !== 2'b10) $display("[TB] FAIL alu_wben_req got %b exp 10", {WbEn, MemReq}); else passed++;
    @(negedge CLK);
    #1;
    total++; if (WbEn !== 1'b0) $display("[TB] FAIL alu_wben_pulse got %b exp 0", WbEn); else passed++;
    // ADDI into $0: value still passes through but no write
    Valid = 1'b1; Ins = 32'h20A00007; Result = 32'h77;
    @(negedge CLK);
    #1;
    total++; if ({WbEn, Wdata} !== {1'b0, 32'h77}) $display("[TB] FAIL addi_r0 got %b/%h exp 0/00000077", WbEn, Wdata); else passed++;
    Ins = 32'h34070005; Result = 32'h5;
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    total++; if ({WbEn, WbReg, Wdata} !== {1'b1, 5'd7, 32'h5}) $display("[TB] FAIL ori got %b/%0d/%h exp 1/7/00000005", WbEn, WbReg, Wdata); else passed++;
  endtask

  task test_lw();
    int stalls;
    stalls = 0;
    Valid = 1'b1; Ins = 32'h8C430004; Result = 32'h100;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        MemAck = 1'b1; MemRdata = 32'hDEADBEEF; Valid = 1'b0;
      end
      #1;
      if (Stall) stalls++;
      if (i == 1) begin
        total++; if ({MemReq, MemWe, MemBe, MemAddr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) $display("[TB] FAIL lw_bus got req=%b we=%b be=%b addr=%h exp 1/0/1111/00000100", MemReq, MemWe, MemBe, MemAddr); else passed++;
      end
      @(negedge CLK);
    end
    MemAck = 1'b0;
    #1;
    total++; if (stalls !== 4) $display("[TB] FAIL lw_stall_cycles got %0d exp 4", stalls); else passed++;
    total++; if ({Wdata, WbReg, WbEn, MemReq} !== {32'hDEADBEEF, 5'd3, 1'b1, 1'b0}) $display("[TB] FAIL lw_wb got %h/%0d/%b/%b exp deadbeef/3/1/0", Wdata, WbReg, WbEn, MemReq); else passed++;
  endtask

  task test_lb_lbu();
    logic [31:0] ins_tab [2];
    logic [31:0] exp_tab [2];
    ins_tab[0] = 32'h80040103; exp_tab[0] = 32'hFFFFFFF0;
    ins_tab[1] = 32'h90040103; exp_tab[1] = 32'h000000F0;
    for (int k = 0; k < 2; k++) begin
      Valid = 1'b1; Ins = ins_tab[k]; Result = 32'h103;
      @(negedge CLK);
      Valid = 1'b0;
      #1;
      total++; if ({MemBe, MemAddr} !== {4'b0001, 32'h100}) $display("[TB] FAIL lb_bus[%0d] got be=%b addr=%h exp 0001/00000100", k, MemBe, MemAddr); else passed++;
      MemAck = 1'b1; MemRdata = 32'h000000F0;
      @(negedge CLK);
      MemAck = 1'b0;
      #1;
      total++; if ({Wdata, WbReg, WbEn} !== {exp_tab[k], 5'd4, 1'b1}) $display("[TB] FAIL lb_wb[%0d] got %h/%0d/%b exp %h/4/1", k, Wdata, WbReg, WbEn, exp_tab[k]); else passed++;
    end
  endtask

  task test_sh();
    Valid = 1'b1; Ins = 32'hA4450002; Result = 32'h202; Rdata2 = 32'h1234ABCD;
    @(negedge CLK);
    Valid = 1'b0;
    MemAck = 1'b1;
    #1;
    total++; if ({MemAddr, MemBe, MemWdata, MemWe} !== {32'h200, 4'b0011, 32'hABCDABCD, 1'b1}) $display("[TB] FAIL sh_bus got addr=%h be=%b wd=%h we=%b exp 00000200/0011/abcdabcd/1", MemAddr, MemBe, MemWdata, MemWe); else passed++;
    total++; if (Stall !== 1'b0) $display("[TB] FAIL sh_stall_ack got %b exp 0", Stall); else passed++;
    @(negedge CLK);
    MemAck = 1'b0;
    #1;
    total++; if ({WbEn, MemReq, Wdata, WbReg} !== {1'b0, 1'b0, 32'h000000F0, 5'd4}) $display("[TB] FAIL sh_done got wben=%b req=%b wd=%h reg=%0d exp 0/0/000000f0/4", WbEn, MemReq, Wdata, WbReg); else passed++;
  endtask

  task test_misalign();
    Valid = 1'b1; Ins = 32'h8C430004; Result = 32'h101;
    #1;
    total++; if (Stall !== 1'b0) $display("[TB] FAIL mis_stall got %b exp 0", Stall); else passed++;
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    total++; if ({AddrErr, MemReq, WbEn} !== 3'b100) $display("[TB] FAIL mis_err got %b exp 100", {AddrErr, MemReq, WbEn}); else passed++;
    @(negedge CLK);
    #1;
    total++; if ({AddrErr, MemReq} !== 2'b00) $display("[TB] FAIL mis_pulse got %b exp 00", {AddrErr, MemReq}); else passed++;
  endtask

  task test_timeout();
    int req;
    logic seen, stall_last;
    req = 0; seen = 1'b0; stall_last = 1'b1;
    Valid = 1'b1; Ins = 32'h8C430004; Result = 32'h100; MemAck = 1'b0;
    @(negedge CLK);
    Valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (BusErr) begin
        seen = 1'b1;
        total++; if ({MemReq, WbEn} !== 2'b00) $display("[TB] FAIL tmo_outputs got %b exp 00", {MemReq, WbEn}); else passed++;
        break;
      end
      if (MemReq) begin
        req++;
        if (req == 16) stall_last = Stall;
      end
      @(negedge CLK);
    end
    total++; if (seen !== 1'b1) $display("[TB] FAIL tmo_buserr got %b exp 1", seen); else passed++;
    total++; if (req !== 16) $display("[TB] FAIL tmo_req_cycles got %0d exp 16", req); else passed++;
    total++; if (stall_last !== 1'b0) $display("[TB] FAIL tmo_stall_last got %b exp 0", stall_last); else passed++;
    @(negedge CLK);
    MemAck = 1'b1;
    #1;
    total++; if (BusErr !== 1'b0) $display("[TB] FAIL tmo_pulse got %b exp 0", BusErr); else passed++;
    @(negedge CLK);
    MemAck = 1'b0;
    #1;
    total++; if ({WbEn, MemReq, BusErr} !== 3'b000) $display("[TB] FAIL stray_ack got %b exp 000", {WbEn, MemReq, BusErr}); else passed++;
  endtask

  task test_ack_at_timeout();
    Valid = 1'b1; Ins = 32'h8C430004; Result = 32'h100;
    @(negedge CLK);
    Valid = 1'b0;
    repeat (15) @(negedge CLK);
    MemAck = 1'b1; MemRdata = 32'h11223344;
    @(negedge CLK);
    MemAck = 1'b0;
    #1;
    total++; if ({BusErr, WbEn, Wdata, MemReq} !== {1'b0, 1'b1, 32'h11223344, 1'b0}) $display("[TB] FAIL ack_tie got buserr=%b wben=%b wd=%h req=%b exp 0/1/11223344/0", BusErr, WbEn, Wdata, MemReq); else passed++;
  endtask

  task test_reset_mid();
    Valid = 1'b1; Ins = 32'h8C430004; Result = 32'h100;
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    total++; if (MemReq !== 1'b1) $display("[TB] FAIL rstmid_req_before got %b exp 1", MemReq); else passed++;
    #1 RST = 1'b1;
    #1;
    total++; if (MemReq !== 1'b0) $display("[TB] FAIL rstmid_async got %b exp 0", MemReq); else passed++;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    total++; if ({WbEn, MemReq} !== 2'b00) $display("[TB] FAIL rstmid_after got %b exp 00", {WbEn, MemReq}); else passed++;
    Valid = 1'b1; Ins = 32'h00851020; Result = 32'h55;
    @(negedge CLK);
    Valid = 1'b0;
    #1;
    total++; if ({Wdata, WbReg, WbEn} !== {32'h55, 5'd2, 1'b1}) $display("[TB] FAIL rstmid_add got %h/%0d/%b exp 00000055/2/1", Wdata, WbReg, WbEn); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
